pipelined_cla_adder: RTL

- Parametrised, two-stage pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides.
- Generalises the fixed 8-bit carry generator to WIDTH bits, split into groups of BLOCK bits:
  - Group-level propagate/generate is computed and registered in stage 1.
  - Group carries, internal carries and the sum are resolved in stage 2.
- Sits in the datapath as a drop-in arithmetic unit for ALU and accumulator paths that need backpressure.

---
 rtl/cla_pkg.sv | 22 ++
 rtl/cla_group_generate.sv | 49 ++++
 rtl/pipelined_cla_adder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// ============================================================================
// cla_pkg : shared constants and helpers for the pipelined CLA adder
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cla_pkg;

  localparam int CLA_WIDTH = 32;
  localparam int CLA_BLOCK = 4;

  function automatic int num_groups(input int width, input int block);
    return width / block;
  endfunction

  function automatic bit cla_params_legal(input int width, input int block);
    return (block >= 2) && (block <= 8) && (width > 0) && ((width % block) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_group_generate.sv
// ============================================================================
// cla_group_generate : BLOCK-bit lookahead group (internal carries, GP, GG)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module cla_group_generate import cla_pkg::*; #(
  parameter int BLOCK = CLA_BLOCK
) (
  input  logic [BLOCK-1:0] p_i,
  input  logic [BLOCK-1:0] g_i,
  input  logic             cin_i,
  output logic [BLOCK-1:0] c_o,
  output logic             gp_o,
  output logic             gg_o
);

  logic w_carry;
  logic w_term;

  // Each carry is a flat sum of products: c[j] = OR_m g[m]&p[m+1..j-1] | cin&p[0..j-1]
  always_comb begin
    c_o     = '0;
    gg_o    = 1'b0;
    w_carry = 1'b0;
    w_term  = 1'b0;
    for (int j = 0; j < BLOCK; j++) begin
      w_term = cin_i;
      for (int k = 0; k < j; k++) w_term = w_term & p_i[k];
      w_carry = w_term;
      for (int m = 0; m < j; m++) begin
        w_term = g_i[m];
        for (int k = m + 1; k < j; k++) w_term = w_term & p_i[k];
        w_carry = w_carry | w_term;
      end
      c_o[j] = w_carry;
    end
    for (int m = 0; m < BLOCK; m++) begin
      w_term = g_i[m];
      for (int k = m + 1; k < BLOCK; k++) w_term = w_term & p_i[k];
      gg_o = gg_o | w_term;
    end
  end

  assign gp_o = &p_i;

endmodule

`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
// ============================================================================
// pipelined_cla_adder : two-stage carry-lookahead add/sub with valid/ready
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pipelined_cla_adder import cla_pkg::*; #(
  parameter int WIDTH = CLA_WIDTH,
  parameter int BLOCK = CLA_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = num_groups(WIDTH, BLOCK);

  if (!cla_params_legal(WIDTH, BLOCK)) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK, BLOCK in 2..8");
  end

  logic [WIDTH-1:0] w_b_eff, w_p, w_g, w_s1_c_unused, w_c, w_sum;
  logic [NG-1:0]    w_gp, w_gg, w_s2_gp_unused, w_s2_gg_unused;
  logic [NG:0]      w_gc;
  logic             w_c0, w_cout, w_ovf, w_adv1, w_adv2;
  logic             w_gc_carry, w_gc_term;

  logic [WIDTH-1:0] s1_p_q, s1_g_q;
  logic [NG-1:0]    s1_gp_q, s1_gg_q;
  logic             s1_c0_q, s1_a_msb_q, s1_b_msb_q;
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  assign w_b_eff = sub ? ~b : b;
  assign w_c0    = sub | ci;
  assign w_p     = a ^ w_b_eff;
  assign w_g     = a & w_b_eff;

  for (genvar k = 0; k < NG; k++) begin : g_s1_group
    cla_group_generate #(.BLOCK(BLOCK)) u_grp (
      .p_i   (w_p[k*BLOCK +: BLOCK]),
      .g_i   (w_g[k*BLOCK +: BLOCK]),
      .cin_i (1'b0),
      .c_o   (w_s1_c_unused[k*BLOCK +: BLOCK]),
      .gp_o  (w_gp[k]),
      .gg_o  (w_gg[k])
    );
  end

  // Inter-group carries, flattened the same way as inside a group
  always_comb begin
    w_gc       = '0;
    w_gc_carry = 1'b0;
    w_gc_term  = 1'b0;
    for (int k = 0; k <= NG; k++) begin
      w_gc_term = s1_c0_q;
      for (int j = 0; j < k; j++) w_gc_term = w_gc_term & s1_gp_q[j];
      w_gc_carry = w_gc_term;
      for (int m = 0; m < k; m++) begin
        w_gc_term = s1_gg_q[m];
        for (int j = m + 1; j < k; j++) w_gc_term = w_gc_term & s1_gp_q[j];
        w_gc_carry = w_gc_carry | w_gc_term;
      end
      w_gc[k] = w_gc_carry;
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_s2_group
    cla_group_generate #(.BLOCK(BLOCK)) u_grp (
      .p_i   (s1_p_q[k*BLOCK +: BLOCK]),
      .g_i   (s1_g_q[k*BLOCK +: BLOCK]),
      .cin_i (w_gc[k]),
      .c_o   (w_c[k*BLOCK +: BLOCK]),
      .gp_o  (w_s2_gp_unused[k]),
      .gg_o  (w_s2_gg_unused[k])
    );
  end

  assign w_sum  = s1_p_q ^ w_c;
  assign w_cout = w_gc[NG];
  // Same-sign operands with a differently-signed result: equals carry-in(MSB) ^ carry-out
  assign w_ovf  = (s1_a_msb_q == s1_b_msb_q) & (w_sum[WIDTH-1] != s1_a_msb_q);

  assign w_adv2   = !s2_valid_q | out_ready;
  assign w_adv1   = !s1_valid_q | w_adv2;
  assign in_ready = w_adv1;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    if (w_adv1) s1_valid_d = in_valid;
    if (w_adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d  = w_sum;
        cout_d = w_cout;
        ovf_d  = w_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv1) begin
      s1_p_q     <= w_p;
      s1_g_q     <= w_g;
      s1_gp_q    <= w_gp;
      s1_gg_q    <= w_gg;
      s1_c0_q    <= w_c0;
      s1_a_msb_q <= a[WIDTH-1];
      s1_b_msb_q <= w_b_eff[WIDTH-1];
    end
  end

  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

`default_nettype wire
